// File: rtl/btpipe_out_buffer.sv
// Output buffer between user logic and an okBTPipeOut endpoint: word FIFO, block
// handshake FSM, sticky error flags and a built-in test-pattern generator.
module btpipe_out_buffer #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned BLOCK_WORDS = 256
) (
  input  logic                      ti_clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      pattern_en,
  input  logic [1:0]                pattern_sel,
  input  logic                      ep_read,
  input  logic                      ep_blockstrobe,
  output logic [DATA_W-1:0]         ep_datain,
  output logic                      ep_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  output logic                      underflow,
  output logic                      proto_err,
  output logic [15:0]               block_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(BLOCK_WORDS) + 1;
  localparam logic [7:0]  FixedByte = 8'hA5;

  typedef enum logic [1:0] {StIdle, StArmed, StXfer} blk_state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DATA_W-1:0] ep_datain_q, ep_datain_d;
  logic              ep_ready_q, ep_ready_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              proto_err_q, proto_err_d;
  logic [15:0]       block_count_q, block_count_d;
  blk_state_e        state_q, state_d;
  logic [CW-1:0]     blk_cnt_q, blk_cnt_d;
  logic              pattern_en_q;
  logic [DATA_W-1:0] gen_cnt_q, gen_cnt_d;
  logic [DATA_W-1:0] gen_walk_q, gen_walk_d;

  logic              fifo_full, fifo_empty;
  logic              wr_req, pop, accept, gen_adv, pat_rise;
  logic [DATA_W-1:0] cnt_cur, walk_cur, fixed_pat, gen_word, wr_word;

  assign fifo_full  = (level_q == LW'(DEPTH));
  assign fifo_empty = (level_q == '0);

  // Pattern generator; on the rising cycle of pattern_en the seed values are
  // used directly so the first generated word is already the seed.
  always_comb begin
    pat_rise = pattern_en & ~pattern_en_q;
    cnt_cur  = pat_rise ? '0 : gen_cnt_q;
    walk_cur = pat_rise ? DATA_W'(1) : gen_walk_q;
    fixed_pat = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      fixed_pat[i] = FixedByte[i % 8];
    end
    gen_word = cnt_cur;
    unique case (pattern_sel)
      2'd0: gen_word = cnt_cur;
      2'd1: gen_word = walk_cur;
      2'd2: gen_word = fixed_pat;
      2'd3: gen_word = ~cnt_cur;
    endcase
  end

  assign wr_req  = pattern_en | wr_en;
  assign wr_word = pattern_en ? gen_word : wr_data;
  assign pop     = ep_read & ~fifo_empty;
  assign accept  = wr_req & (~fifo_full | pop);
  assign gen_adv = accept & pattern_en;

  always_comb begin
    gen_cnt_d  = cnt_cur + DATA_W'(gen_adv);
    gen_walk_d = gen_adv ? {walk_cur[DATA_W-2:0], walk_cur[DATA_W-1]} : walk_cur;
  end

  // FIFO datapath and sticky flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + AW'(accept);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    level_d     = level_q + LW'(accept) - LW'(pop);
    ep_datain_d = ep_datain_q;
    if (pop) begin
      ep_datain_d = mem_q[rd_ptr_q];
    end else if (ep_read) begin
      ep_datain_d = '0;
    end
    overflow_d  = overflow_q | (wr_req & fifo_full & ~pop);
    underflow_d = underflow_q | (ep_read & fifo_empty);
  end

  // Block handshake FSM; a strobe outside IDLE restarts the block in ARMED.
  always_comb begin
    state_d       = state_q;
    blk_cnt_d     = blk_cnt_q;
    block_count_d = block_count_q;
    proto_err_d   = proto_err_q;
    unique case (state_q)
      StIdle: begin
        if (ep_read) begin
          proto_err_d = 1'b1;
        end
        if (ep_blockstrobe) begin
          state_d   = StArmed;
          blk_cnt_d = '0;
        end
      end
      StArmed, StXfer: begin
        if (ep_blockstrobe) begin
          proto_err_d = 1'b1;
          state_d     = StArmed;
          blk_cnt_d   = '0;
        end else if (ep_read) begin
          blk_cnt_d = blk_cnt_q + CW'(1);
          if (blk_cnt_q + CW'(1) == CW'(BLOCK_WORDS)) begin
            state_d       = StIdle;
            blk_cnt_d     = '0;
            block_count_d = block_count_q + 16'd1;
          end else begin
            state_d = StXfer;
          end
        end
      end
      default: begin
        state_d   = StIdle;
        blk_cnt_d = '0;
      end
    endcase
    ep_ready_d = (state_d == StIdle) && (level_d >= LW'(BLOCK_WORDS));
  end

  always_ff @(posedge ti_clk) begin
    if (!rst && accept) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
  end

  always_ff @(posedge ti_clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      ep_datain_q   <= '0;
      ep_ready_q    <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      proto_err_q   <= 1'b0;
      block_count_q <= '0;
      state_q       <= StIdle;
      blk_cnt_q     <= '0;
      pattern_en_q  <= 1'b0;
      gen_cnt_q     <= '0;
      gen_walk_q    <= DATA_W'(1);
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      ep_datain_q   <= ep_datain_d;
      ep_ready_q    <= ep_ready_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      proto_err_q   <= proto_err_d;
      block_count_q <= block_count_d;
      state_q       <= state_d;
      blk_cnt_q     <= blk_cnt_d;
      pattern_en_q  <= pattern_en;
      gen_cnt_q     <= gen_cnt_d;
      gen_walk_q    <= gen_walk_d;
    end
  end

  assign ep_datain   = ep_datain_q;
  assign ep_ready    = ep_ready_q;
  assign level       = level_q;
  assign full        = fifo_full;
  assign empty       = fifo_empty;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign proto_err   = proto_err_q;
  assign block_count = block_count_q;

endmodule

// File: tb/tb_btpipe_out_buffer.sv
// Bench for btpipe_out_buffer: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_btpipe_out_buffer;

  localparam int unsigned DW = 32;
  localparam int unsigned DP = 16;
  localparam int unsigned BW = 4;

  logic          ti_clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          pattern_en = 1'b0;
  logic [1:0]    pattern_sel = 2'd0;
  logic          ep_read = 1'b0;
  logic          ep_blockstrobe = 1'b0;
  logic [DW-1:0] ep_datain;
  logic          ep_ready;
  logic [4:0]    level;
  logic          full, empty, overflow, underflow, proto_err;
  logic [15:0]   block_count;

  int n_checks = 0;
  int n_fail   = 0;

  btpipe_out_buffer #(.DATA_W(DW), .DEPTH(DP), .BLOCK_WORDS(BW)) dut (
    .ti_clk         (ti_clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .pattern_en     (pattern_en),
    .pattern_sel    (pattern_sel),
    .ep_read        (ep_read),
    .ep_blockstrobe (ep_blockstrobe),
    .ep_datain      (ep_datain),
    .ep_ready       (ep_ready),
    .level          (level),
    .full           (full),
    .empty          (empty),
    .overflow       (overflow),
    .underflow      (underflow),
    .proto_err      (proto_err),
    .block_count    (block_count)
  );

  always #5 ti_clk = ~ti_clk;

  // Reference model: the FIFO is a queue, the block handshake a phase + read count.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout, m_gc, m_gw;
  bit            m_ready, m_of, m_uf, m_pe, m_pe_prev;
  logic [15:0]   m_bc;
  int            m_phase;  // 0 idle, 1 armed, 2 transferring
  int            m_reads;

  task automatic model_step();
    logic [DW-1:0] word;
    bit was_full, popped, wreq;
    if (rst) begin
      mq.delete();
      m_dout = '0; m_ready = 0; m_of = 0; m_uf = 0; m_pe = 0;
      m_bc = '0; m_phase = 0; m_reads = 0;
      m_gc = '0; m_gw = 32'd1; m_pe_prev = 0;
      return;
    end
    wreq = pattern_en || wr_en;
    if (pattern_en && !m_pe_prev) begin
      m_gc = '0; m_gw = 32'd1;
    end
    case (pattern_sel)
      2'd0: word = m_gc;
      2'd1: word = m_gw;
      2'd2: word = 32'hA5A5_A5A5;
      default: word = ~m_gc;
    endcase
    if (!pattern_en) word = wr_data;
    was_full = (mq.size() == DP);
    popped   = ep_read && (mq.size() > 0);
    if (ep_read) begin
      if (mq.size() > 0) m_dout = mq.pop_front();
      else begin m_dout = '0; m_uf = 1; end
    end
    if (wreq) begin
      if (!was_full || popped) begin
        mq.push_back(word);
        if (pattern_en) begin
          m_gc = m_gc + 1;
          m_gw = {m_gw[DW-2:0], m_gw[DW-1]};
        end
      end else m_of = 1;
    end
    if (ep_read && m_phase == 0) m_pe = 1;
    if (ep_blockstrobe) begin
      if (m_phase != 0) m_pe = 1;
      m_phase = 1; m_reads = 0;
    end else if (ep_read && m_phase != 0) begin
      m_reads++;
      m_phase = 2;
      if (m_reads == BW) begin m_phase = 0; m_reads = 0; m_bc = m_bc + 1; end
    end
    m_ready = (m_phase == 0) && (mq.size() >= BW);
    m_pe_prev = pattern_en;
  endtask

  task automatic tick();
    @(posedge ti_clk);
    #1;
    model_step();
  endtask

  task automatic clr_inputs();
    rst = 0; wr_en = 0; wr_data = '0; pattern_en = 0;
    ep_read = 0; ep_blockstrobe = 0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    wr_en = 1; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic strobe();
    ep_blockstrobe = 1;
    tick();
    ep_blockstrobe = 0;
  endtask

  task automatic read_word();
    ep_read = 1;
    tick();
    ep_read = 0;
  endtask

  task automatic test_reset();
    clr_inputs();
    rst = 1; wr_en = 1; wr_data = 32'h55; ep_read = 1; ep_blockstrobe = 1;
    tick();
    clr_inputs();
    n_checks++;
    if ({ep_datain, ep_ready, level, full, empty} !== {32'h0, 1'b0, 5'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_fifo: got dout=%h rdy=%b lvl=%0d full=%b empty=%b, want 0 0 0 0 1",
               ep_datain, ep_ready, level, full, empty);
    end
    n_checks++;
    if ({overflow, underflow, proto_err, block_count} !== {3'b000, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_flags: got of=%b uf=%b pe=%b bc=%0d, want 0 0 0 0",
               overflow, underflow, proto_err, block_count);
    end
  endtask

  task automatic test_basic_block();
    do_reset();
    for (int i = 0; i < 3; i++) write_word(32'h10 + i);
    n_checks++;
    if (ep_ready !== 1'b0 || level !== 5'd3) begin
      n_fail++;
      $display("FAIL level3_ready: got rdy=%b lvl=%0d, want 0 3", ep_ready, level);
    end
    write_word(32'h13);
    n_checks++;
    if (ep_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL level4_ready: got %b want 1", ep_ready);
    end
    strobe();
    n_checks++;
    if (ep_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_after_strobe: got %b want 0", ep_ready);
    end
    for (int i = 0; i < 4; i++) begin
      read_word();
      n_checks++;
      if (ep_datain !== 32'h10 + i) begin
        n_fail++;
        $display("FAIL basic_data%0d: got %h want %h", i, ep_datain, 32'h10 + i);
      end
    end
    tick();
    n_checks++;
    if (ep_datain !== 32'h13) begin
      n_fail++;
      $display("FAIL dout_hold: got %h want 00000013", ep_datain);
    end
    n_checks++;
    if (block_count !== 16'd1 || level !== 5'd0 || proto_err !== 1'b0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_end: got bc=%0d lvl=%0d pe=%b empty=%b, want 1 0 0 1",
               block_count, level, proto_err, empty);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    ep_read = 1; wr_en = 1; wr_data = 32'hDEAD_BEEF;
    tick();
    clr_inputs();
    n_checks++;
    if (ep_datain !== 32'h0 || underflow !== 1'b1 || level !== 5'd1) begin
      n_fail++;
      $display("FAIL underflow: got dout=%h uf=%b lvl=%0d, want 0 1 1", ep_datain, underflow, level);
    end
    n_checks++;
    if (proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL read_in_idle: got pe=%b want 1", proto_err);
    end
    read_word();
    n_checks++;
    if (ep_datain !== 32'hDEAD_BEEF || level !== 5'd0) begin
      n_fail++;
      $display("FAIL no_bypass_word: got %h lvl=%0d want deadbeef 0", ep_datain, level);
    end
  endtask

  task automatic test_pattern(input logic [1:0] sel, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                              input logic [DW-1:0] e2, input logic [DW-1:0] e3);
    logic [DW-1:0] expv [4];
    expv = '{e0, e1, e2, e3};
    do_reset();
    pattern_en = 1; pattern_sel = sel;
    repeat (20) tick();
    pattern_en = 0;
    n_checks++;
    if (level !== 5'd16 || full !== 1'b1 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL pattern%0d_fill: got lvl=%0d full=%b of=%b, want 16 1 1",
               sel, level, full, overflow);
    end
    strobe();
    for (int i = 0; i < 4; i++) begin
      read_word();
      n_checks++;
      if (ep_datain !== expv[i]) begin
        n_fail++;
        $display("FAIL pattern%0d_word%0d: got %h want %h", sel, i, ep_datain, expv[i]);
      end
    end
  endtask

  task automatic test_full_simul();
    logic [DW-1:0] expq[$];
    do_reset();
    for (int i = 0; i < 16; i++) begin
      expq.push_back($urandom);
      write_word(expq[i]);
    end
    n_checks++;
    if (full !== 1'b1 || ep_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_fill: got full=%b rdy=%b want 1 1", full, ep_ready);
    end
    strobe();
    wr_en = 1; wr_data = 32'hAA; ep_read = 1;
    tick();
    clr_inputs();
    expq.push_back(32'hAA);
    n_checks++;
    if (level !== 5'd16 || overflow !== 1'b0 || ep_datain !== expq[0]) begin
      n_fail++;
      $display("FAIL full_simul: got lvl=%0d of=%b dout=%h, want 16 0 %h",
               level, overflow, ep_datain, expq[0]);
    end
    for (int k = 1; k <= 16; k++) begin
      if (k % 4 == 0) strobe();
      read_word();
      n_checks++;
      if (ep_datain !== expq[k]) begin
        n_fail++;
        $display("FAIL full_drain%0d: got %h want %h", k, ep_datain, expq[k]);
      end
    end
    n_checks++;
    if (ep_datain !== 32'hAA || block_count !== 16'd4 || proto_err !== 1'b0 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_end: got dout=%h bc=%0d pe=%b uf=%b, want aa 4 0 0",
               ep_datain, block_count, proto_err, underflow);
    end
  endtask

  task automatic test_proto();
    do_reset();
    for (int i = 0; i < 8; i++) write_word(32'h100 + i);
    strobe();
    read_word();
    read_word();
    strobe();
    n_checks++;
    if (proto_err !== 1'b1 || ep_ready !== 1'b0 || block_count !== 16'd0) begin
      n_fail++;
      $display("FAIL proto_restrobe: got pe=%b rdy=%b bc=%0d, want 1 0 0",
               proto_err, ep_ready, block_count);
    end
    for (int i = 0; i < 4; i++) begin
      read_word();
      n_checks++;
      if (ep_datain !== 32'h102 + i) begin
        n_fail++;
        $display("FAIL proto_data%0d: got %h want %h", i, ep_datain, 32'h102 + i);
      end
    end
    n_checks++;
    if (block_count !== 16'd1 || level !== 5'd2) begin
      n_fail++;
      $display("FAIL proto_block: got bc=%0d lvl=%0d want 1 2", block_count, level);
    end
    for (int i = 0; i < 4; i++) write_word(32'h200 + i);
    strobe();
    read_word();
    rst = 1;
    tick();
    rst = 0;
    n_checks++;
    if ({ep_datain, ep_ready, level, full, empty, overflow, underflow, proto_err, block_count} !==
        {32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 3'b000, 16'd0}) begin
      n_fail++;
      $display("FAIL midblock_reset: got dout=%h rdy=%b lvl=%0d full=%b empty=%b of=%b uf=%b pe=%b bc=%0d",
               ep_datain, ep_ready, level, full, empty, overflow, underflow, proto_err, block_count);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst            = ($urandom_range(0, 149) == 0);
      wr_en          = ($urandom_range(0, 1) == 1);
      wr_data        = $urandom;
      ep_read        = ($urandom_range(0, 9) < 4);
      ep_blockstrobe = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 19) == 0) begin
        pattern_en  = ~pattern_en;
        pattern_sel = 2'($urandom_range(0, 3));
      end
      tick();
      n_checks++;
      if (ep_datain !== m_dout) begin
        n_fail++;
        $display("FAIL rand_dout@%0d: got %h want %h", c, ep_datain, m_dout);
      end
      n_checks++;
      if (level !== 5'(mq.size()) || full !== (mq.size() == DP) || empty !== (mq.size() == 0)) begin
        n_fail++;
        $display("FAIL rand_level@%0d: got lvl=%0d full=%b empty=%b want lvl=%0d",
                 c, level, full, empty, mq.size());
      end
      n_checks++;
      if ({ep_ready, overflow, underflow, proto_err} !== {m_ready, m_of, m_uf, m_pe}) begin
        n_fail++;
        $display("FAIL rand_flags@%0d: got rdy/of/uf/pe=%b%b%b%b want %b%b%b%b", c,
                 ep_ready, overflow, underflow, proto_err, m_ready, m_of, m_uf, m_pe);
      end
      n_checks++;
      if (block_count !== m_bc) begin
        n_fail++;
        $display("FAIL rand_blocks@%0d: got %0d want %0d", c, block_count, m_bc);
      end
    end
    clr_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_block();
    test_underflow();
    test_pattern(2'd0, 32'h0, 32'h1, 32'h2, 32'h3);
    test_pattern(2'd1, 32'h1, 32'h2, 32'h4, 32'h8);
    test_pattern(2'd2, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    test_pattern(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC);
    test_full_simul();
    test_proto();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
